// File: rtl/sw_debounce_if.sv
// sw_debounce_if: raw pin inputs and debounced outputs of sw_debounce.
// rise_pulse/fall_pulse exist only when SW_DEBOUNCE_PULSE_EN is defined.
interface sw_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic changed;
`ifdef SW_DEBOUNCE_PULSE_EN
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  modport master (output raw_in, input clean_out, changed, rise_pulse, fall_pulse);
  modport slave (input raw_in, output clean_out, changed, rise_pulse, fall_pulse);
`else
  modport master (output raw_in, input clean_out, changed);
  modport slave (input raw_in, output clean_out, changed);
`endif
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer plus per-channel tick-counted debounce for switch/button pins.
// Define SW_DEBOUNCE_PULSE_EN to add per-bit rise_pulse/fall_pulse outputs.
module sw_debounce #(
  parameter int WIDTH = 10,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 10
) (
  input logic clk,
  input logic reset_n,
  sw_debounce_if.slave sw
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  logic [WIDTH-1:0] s1_q, s2_q, clean_q, clean_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  logic changed_q, changed_d;
  logic tick;
  always_comb begin
    tick = pre_q == PW'(TICK_DIV - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      // any single matching cycle restarts the count, tick or not
      cnt_d[i] = (s2_q[i] == clean_q[i]) ? '0 :
                 !tick ? cnt_q[i] :
                 (cnt_q[i] == CW'(STABLE_TICKS - 1)) ? '0 : cnt_q[i] + 1'b1;
      clean_d[i] = (s2_q[i] != clean_q[i] && tick && cnt_q[i] == CW'(STABLE_TICKS - 1)) ? s2_q[i] : clean_q[i];
    end
    changed_d = |(clean_d ^ clean_q);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      pre_q <= '0;
      clean_q <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= sw.raw_in;
      s2_q <= s1_q;
      pre_q <= pre_d;
      clean_q <= clean_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign sw.clean_out = clean_q;
  assign sw.changed = changed_q;
`ifdef SW_DEBOUNCE_PULSE_EN
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign sw.rise_pulse = rise_q;
  assign sw.fall_pulse = fall_q;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: scenario tasks plus randomized stimulus against a tick-counting reference model;
// a second instance covers the TICK_DIV=1, STABLE_TICKS=1 corner.
module tb_sw_debounce;
  localparam int W = 10;
  localparam int TD = 4;
  localparam int ST = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int total = 0;
  int bad = 0;
  int nchg = 0;
  logic [W-1:0] m_s1, m_s2, m_clean, m_rise, m_fall, m_act, cur;
  logic m_chg;
  int m_start [W];
  int k;

  sw_debounce_if #(.WIDTH(W)) sw ();
  sw_debounce_if #(.WIDTH(W)) sw2 ();
  sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (.clk(clk), .reset_n(reset_n), .sw(sw));
  sw_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1)) dut1 (.clk(clk), .reset_n(reset_n), .sw(sw2));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_clean = '0;
    m_act = '0;
    k = 0;
  endtask

  // One clock: drive raw, advance the model, check outputs just after the edge, return at negedge.
  // The model flips a bit once ST prescaler ticks (edges with k%TD==TD-1) fall inside its
  // current uninterrupted disagreement run [start, k].
  task automatic step(input logic [W-1:0] r);
    logic [W-1:0] nc;
    cur = r;
    sw.raw_in = r;
    @(posedge clk);
    nc = m_clean;
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] == m_clean[i]) m_act[i] = 1'b0;
      else begin
        if (!m_act[i]) begin
          m_act[i] = 1'b1;
          m_start[i] = k;
        end
        if ((k + 1) / TD - m_start[i] / TD >= ST) begin
          nc[i] = m_s2[i];
          m_act[i] = 1'b0;
        end
      end
    end
    m_rise = nc & ~m_clean;
    m_fall = ~nc & m_clean;
    m_chg = |(nc ^ m_clean);
    m_clean = nc;
    m_s2 = m_s1;
    m_s1 = r;
    k++;
    #1;
    total++;
    if (sw.clean_out !== m_clean) begin
      bad++;
      $display("FAIL clean_out k=%0d got=%h exp=%h", k, sw.clean_out, m_clean);
    end
    total++;
    if (sw.changed !== m_chg) begin
      bad++;
      $display("FAIL changed k=%0d got=%b exp=%b", k, sw.changed, m_chg);
    end
`ifdef SW_DEBOUNCE_PULSE_EN
    total++;
    if (sw.rise_pulse !== m_rise) begin
      bad++;
      $display("FAIL rise_pulse k=%0d got=%h exp=%h", k, sw.rise_pulse, m_rise);
    end
    total++;
    if (sw.fall_pulse !== m_fall) begin
      bad++;
      $display("FAIL fall_pulse k=%0d got=%h exp=%h", k, sw.fall_pulse, m_fall);
    end
`endif
    if (sw.changed === 1'b1) nchg++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    sw.raw_in = '0;
    sw2.raw_in = '0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    total++;
    if (sw.clean_out !== '0) begin
      bad++;
      $display("FAIL reset_clean got=%h exp=0", sw.clean_out);
    end
    total++;
    if (sw.changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_changed got=%b exp=0", sw.changed);
    end
    total++;
    if (sw2.clean_out !== '0) begin
      bad++;
      $display("FAIL reset_clean2 got=%h exp=0", sw2.clean_out);
    end
`ifdef SW_DEBOUNCE_PULSE_EN
    total++;
    if (sw.rise_pulse !== '0 || sw.fall_pulse !== '0) begin
      bad++;
      $display("FAIL reset_pulses got=%h/%h exp=0/0", sw.rise_pulse, sw.fall_pulse);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_clean_step();
    int lat = 0;
    nchg = 0;
    for (int n = 1; n <= 20; n++) begin
      step(10'h001);
      if (lat == 0 && sw.clean_out[0] === 1'b1) lat = n;
    end
    total++;
    if (lat < 11 || lat > 14) begin
      bad++;
      $display("FAIL step_latency got=%0d exp=11..14", lat);
    end
    total++;
    if (nchg != 1) begin
      bad++;
      $display("FAIL step_changed_count got=%0d exp=1", nchg);
    end
    for (int n = 0; n < 16; n++) step('0);
  endtask

  task automatic test_bounce_reject();
    logic v = 1'b1;
    nchg = 0;
    for (int p = 0; p < 20; p++) begin
      for (int n = 0; n < 3; n++) step(v ? 10'h008 : 10'h000);
      v = ~v;
    end
    for (int n = 0; n < 20; n++) step('0);
    total++;
    if (nchg != 0 || sw.clean_out[3] !== 1'b0) begin
      bad++;
      $display("FAIL bounce_reject changed=%0d clean3=%b exp=0/0", nchg, sw.clean_out[3]);
    end
  endtask

  task automatic test_bounce_settle();
    int lat = 0;
    nchg = 0;
    for (int p = 0; p < 10; p++) begin
      for (int n = 0; n < 2; n++) step((p % 2 == 0) ? 10'h020 : 10'h000);
    end
    for (int n = 1; n <= 20; n++) begin
      step(10'h020);
      if (lat == 0 && sw.clean_out[5] === 1'b1) lat = n;
    end
    total++;
    if (lat == 0 || lat > 14) begin
      bad++;
      $display("FAIL settle_latency got=%0d exp=1..14", lat);
    end
    total++;
    if (nchg != 1) begin
      bad++;
      $display("FAIL settle_changed_count got=%0d exp=1", nchg);
    end
    for (int n = 0; n < 16; n++) step('0);
  endtask

  task automatic test_simultaneous();
    nchg = 0;
    for (int n = 0; n < 20; n++) begin
      step(10'h3FF);
      total++;
      if (sw.clean_out !== 10'h000 && sw.clean_out !== 10'h3FF) begin
        bad++;
        $display("FAIL simul_split got=%h exp=000|3FF", sw.clean_out);
      end
`ifdef SW_DEBOUNCE_PULSE_EN
      total++;
      if (sw.fall_pulse !== '0) begin
        bad++;
        $display("FAIL simul_fall got=%h exp=0", sw.fall_pulse);
      end
`endif
    end
    total++;
    if (nchg != 1 || sw.clean_out !== 10'h3FF) begin
      bad++;
      $display("FAIL simul_final changed=%0d clean=%h exp=1/3FF", nchg, sw.clean_out);
    end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    for (int n = 0; n < 8; n++) step(10'h002);
    reset_n = 1'b0;
    #1;
    total++;
    if (sw.clean_out !== '0 || sw.changed !== 1'b0) begin
      bad++;
      $display("FAIL async_clear clean=%h changed=%b exp=0/0", sw.clean_out, sw.changed);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int n = 1; n <= 20; n++) begin
      step(10'h002);
      if (lat == 0 && sw.clean_out[1] === 1'b1) lat = n;
    end
    total++;
    if (lat < 11 || lat > 14) begin
      bad++;
      $display("FAIL reset_mid_latency got=%0d exp=11..14", lat);
    end
    for (int n = 0; n < 16; n++) step('0);
  endtask

  task automatic test_tick_div1();
    int lat = 0;
    total++;
    if (sw2.clean_out !== '0) begin
      bad++;
      $display("FAIL td1_idle got=%h exp=0", sw2.clean_out);
    end
    sw2.raw_in = 10'h200;
    for (int n = 1; n <= 10; n++) begin
      step(cur);
      if (lat == 0 && sw2.clean_out[9] === 1'b1) begin
        lat = n;
        total++;
        if (sw2.changed !== 1'b1) begin
          bad++;
          $display("FAIL td1_changed got=%b exp=1", sw2.changed);
        end
      end
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL td1_latency got=%0d exp=3", lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r = '0;
    int idx;
    for (int s = 0; s < 50; s++) begin
      if ($urandom_range(0, 1) == 0) r = W'($urandom_range(0, 1023));
      repeat ($urandom_range(1, 30)) begin
        if ($urandom_range(0, 3) == 0) begin
          idx = $urandom_range(0, W - 1);
          r[idx] = ~r[idx];
        end
        step(r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce_reject();
    test_bounce_settle();
    test_simultaneous();
    test_reset_mid();
    test_tick_div1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Synchronizes and debounces the raw slide-switch and push-button inputs from the board pins before they reach the switch PIO's `in_port`. Without it, the PIO edge-capture register latches spurious edges from contact bounce. Each bit passes through a 2-flop synchronizer and a per-channel stability counter clocked by a shared prescaler tick. A bit's clean output changes only after its input has disagreed with the clean output for STABLE_TICKS consecutive ticks.

## Interface
Parameters:
- WIDTH, 10, number of independent input channels
- TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); legal range ≥1
- STABLE_TICKS, 10, consecutive ticks of disagreement required to flip an output; legal range ≥1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- raw_in  in  WIDTH  asynchronous pin inputs
- clean_out  out  WIDTH  debounced level; drives PIO `in_port`
- changed  out  1  one-cycle pulse in the cycle any clean_out bit takes a new value
- rise_pulse  out  WIDTH  one-cycle per-bit 0→1 pulse; present only with SW_DEBOUNCE_PULSE_EN
- fall_pulse  out  WIDTH  one-cycle per-bit 1→0 pulse; present only with SW_DEBOUNCE_PULSE_EN

## Operation
- **Reset:** on reset, sync stages, prescaler, all channel counters, clean_out, changed, rise_pulse and fall_pulse are 0. Asserting reset mid-count discards all partial progress.
- **Synchronizer:** s1 <= raw_in; s2 <= s1. Only s2 is used downstream.
- **Prescaler:** counter of width max(1, clog2(TICK_DIV)).
  - The counter runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is asserted combinationally while counter == TICK_DIV-1.
  - With TICK_DIV=1, tick is asserted every cycle.
- **Per-channel counter** `cnt[i]`, width clog2(STABLE_TICKS+1). Each clk edge:
  - If s2[i] == clean_out[i]: cnt[i] <= 0. A match on any single cycle restarts the count, including on non-tick cycles.
  - Else if tick and cnt[i] == STABLE_TICKS-1: clean_out[i] <= s2[i] and cnt[i] <= 0.
  - Else if tick: cnt[i] <= cnt[i]+1.
  - Otherwise: hold.
- **Channel independence:** channels are independent. Several bits may flip in the same cycle.
- **changed:** registered; 1 for exactly the cycle in which any clean_out bit shows its new value, else 0.
- **Steady state:** no flip occurs while the input is steady; clean_out never glitches.

## Timing
- Input-to-s2 latency is 2 clk.
- After s2 settles at a new value, clean_out follows after between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV clk. The exact figure depends on prescaler phase.
- Worst-case raw_in→clean_out latency is 2 + STABLE_TICKS·TICK_DIV clk.
- changed, rise_pulse and fall_pulse are registered in the same edge as the clean_out update, so they are coincident with it.
- There is no handshake. The downstream PIO samples clean_out every cycle; its edge detector then adds its own 2-cycle delay.
- A bounce shorter than one tick period can still be missed or reset a count. The only guarantee is that an output flips solely after the count completes.

## Configuration
- **SW_DEBOUNCE_PULSE_EN defined:** rise_pulse and fall_pulse ports exist.
  - rise_pulse[i] = 1 for the one cycle in which clean_out[i] goes 0→1.
  - fall_pulse[i] = 1 for the one cycle in which clean_out[i] goes 1→0.
  - Both reset to 0.
- **SW_DEBOUNCE_PULSE_EN undefined:** both ports and their registers are absent. clean_out and changed behave identically in both builds.

## Test plan
All scenarios use WIDTH=10, TICK_DIV=4, STABLE_TICKS=3.
- **Clean step:** raw_in[0] 0→1 and held -> clean_out[0]=1 between 11 and 14 clk after raw change. changed=1 for exactly that cycle. rise_pulse[0]=1 that cycle when SW_DEBOUNCE_PULSE_EN is defined.
- **Bounce rejection:** raw_in[3] toggles every 3 clk for 60 clk, then held 0 -> clean_out[3] stays 0 and changed never asserts.
- **Bounce then settle:** raw_in[5] toggles every 2 clk for 20 clk, then held 1 -> clean_out[5]=1 no later than 14 clk after the last toggle. Exactly one changed pulse.
- **Simultaneous channels:** raw_in 0x000→0x3FF in one cycle -> all 10 bits of clean_out flip in the same cycle. A single one-cycle changed pulse. fall_pulse stays 0.
- **Reset mid-count:** raw_in[1]=1; pulse reset_n low 8 clk later -> clean_out=0 immediately and all counters cleared. Flip occurs 11–14 clk after reset release, not earlier.
- **TICK_DIV=1 corner:** rebuild with TICK_DIV=1, STABLE_TICKS=1, raw_in[9] 0→1 -> clean_out[9]=1 exactly 3 clk after the raw change.
